// File: rtl/sync_deglitch.sv
// ---------------------------------------------------------------------------
// sync_deglitch
//
// Per-bit glitch filter and edge detector for control bits that have already
// been brought into the local clock domain by a two-flop synchronizer. A new
// input level is accepted only after it has differed from the filtered level
// for filt_len+1 consecutive enabled samples. The block then produces the
// filtered level, one-cycle rise/fall pulses and a wrapping count of cycles
// in which at least one bit qualified.
//
// Ports
//   clk       in   block clock
//   rstn      in   asynchronous active-low reset
//   din       in   [DATA_WIDTH]  synchronized input bits
//   en        in   filter enable; 0 holds dout and clears stability counters
//   filt_len  in   [CNT_WIDTH]   extra stable cycles required (quasi-static)
//   evt_clr   in   synchronous clear of evt_cnt (wins over an increment)
//   dout      out  [DATA_WIDTH]  filtered level, registered
//   rise      out  [DATA_WIDTH]  one-cycle pulse when dout[i] goes 0->1
//   fall      out  [DATA_WIDTH]  one-cycle pulse when dout[i] goes 1->0
//   evt_cnt   out  [EVT_WIDTH]   wrapping count of qualifying cycles
// ---------------------------------------------------------------------------
module sync_deglitch #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    CNT_WIDTH  = 8,
    parameter int                    EVT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  en,
    input  logic [CNT_WIDTH-1:0]  filt_len,
    input  logic                  evt_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] rise,
    output logic [DATA_WIDTH-1:0] fall,
    output logic [EVT_WIDTH-1:0]  evt_cnt
);

    logic [DATA_WIDTH-1:0]                dout_q,    dout_d;
    logic [DATA_WIDTH-1:0]                rise_q,    rise_d;
    logic [DATA_WIDTH-1:0]                fall_q,    fall_d;
    logic [DATA_WIDTH-1:0][CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [EVT_WIDTH-1:0]                 evt_cnt_q, evt_cnt_d;
    logic [DATA_WIDTH-1:0]                qual;

    always_comb begin
        qual  = '0;
        cnt_d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (en && (din[i] != dout_q[i])) begin
                // '>=' rather than '==' so that lowering filt_len below a
                // count already in progress qualifies on the next differing
                // sample instead of letting the counter run on and wrap.
                if (cnt_q[i] >= filt_len) begin
                    qual[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        dout_d = dout_q ^ qual;
        rise_d = qual & din;
        fall_d = qual & ~din;

        if (evt_clr) begin
            evt_cnt_d = '0;
        end else begin
            evt_cnt_d = evt_cnt_q + {{(EVT_WIDTH-1){1'b0}}, |qual};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q    <= INIT_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            cnt_q     <= '0;
            evt_cnt_q <= '0;
        end else begin
            dout_q    <= dout_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            cnt_q     <= cnt_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign dout    = dout_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_sync_deglitch.sv
// ---------------------------------------------------------------------------
// tb_sync_deglitch
//
// Self-checking bench for sync_deglitch. A behavioural model tracks, per bit,
// the length of the current run of consecutive enabled samples that differ
// from the filtered level; a bit is accepted once that run exceeds filt_len.
// ---------------------------------------------------------------------------
module tb_sync_deglitch;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int EW = 16;
    localparam logic [DW-1:0] INIT = '0;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] din;
    logic          en;
    logic [CW-1:0] filt_len;
    logic          evt_clr;
    logic [DW-1:0] dout;
    logic [DW-1:0] rise;
    logic [DW-1:0] fall;
    logic [EW-1:0] evt_cnt;

    sync_deglitch #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .EVT_WIDTH  (EW),
        .INIT_VALUE (INIT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .din      (din),
        .en       (en),
        .filt_len (filt_len),
        .evt_clr  (evt_clr),
        .dout     (dout),
        .rise     (rise),
        .fall     (fall),
        .evt_cnt  (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state
    logic [DW-1:0] m_dout, m_rise, m_fall;
    logic [EW-1:0] m_evt;
    int            run [DW];

    task automatic model_reset();
        m_dout = INIT;
        m_rise = '0;
        m_fall = '0;
        m_evt  = '0;
        for (int i = 0; i < DW; i++) run[i] = 0;
    endtask

    // Advance one clock: the model samples the same inputs the DUT samples at
    // the edge; outputs are then compared 1 time unit later.
    task automatic tick();
        logic [DW-1:0] q;
        @(posedge clk);
        if (rstn) begin
            q = '0;
            for (int i = 0; i < DW; i++) begin
                if (en && din[i] != m_dout[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] > int'(filt_len)) begin
                        q[i]   = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_rise = q & din;
            m_fall = q & ~din;
            m_dout = m_dout ^ q;
            if (evt_clr)      m_evt = '0;
            else if (q != '0) m_evt = m_evt + 1'b1;
        end
        #1;
    endtask

    // Bring the design to a known quiet state: din=0, dout=0, no pulses.
    task automatic settle();
        din = '0; en = 1'b1; filt_len = '0; evt_clr = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; din = '0; en = 1'b1; filt_len = 8'd3; evt_clr = 1'b0;
        model_reset();
        #3;
        n_checks++; if (dout !== INIT) begin n_fail++; $display("FAIL reset_dout got %h want %h", dout, INIT); end
        n_checks++; if (rise !== '0) begin n_fail++; $display("FAIL reset_rise got %h want 0", rise); end
        n_checks++; if (fall !== '0) begin n_fail++; $display("FAIL reset_fall got %h want 0", fall); end
        n_checks++; if (evt_cnt !== '0) begin n_fail++; $display("FAIL reset_evt got %h want 0", evt_cnt); end
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_basic_rise_fall();
        settle();
        filt_len = 8'd3;
        din[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL basic_hold%0d got %b want 0", k, dout[0]); end
        end
        tick();
        n_checks++; if (dout[0] !== 1'b1 || rise[0] !== 1'b1) begin n_fail++; $display("FAIL basic_rise got dout=%b rise=%b want 1 1", dout[0], rise[0]); end
        n_checks++; if (evt_cnt !== m_evt) begin n_fail++; $display("FAIL basic_evt1 got %0d want %0d", evt_cnt, m_evt); end
        tick();
        n_checks++; if (rise !== '0) begin n_fail++; $display("FAIL basic_rise_once got %h want 0", rise); end
        din[0] = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (dout[0] !== 1'b1 || fall !== '0) begin n_fail++; $display("FAIL basic_fall_early got dout=%b fall=%h", dout[0], fall); end
        tick();
        n_checks++; if (dout[0] !== 1'b0 || fall[0] !== 1'b1) begin n_fail++; $display("FAIL basic_fall got dout=%b fall=%b want 0 1", dout[0], fall[0]); end
        n_checks++; if (evt_cnt !== m_evt) begin n_fail++; $display("FAIL basic_evt2 got %0d want %0d", evt_cnt, m_evt); end
    endtask

    task automatic test_glitch();
        logic [EW-1:0] e0;
        settle();
        e0 = m_evt;
        filt_len = 8'd3;
        din[2] = 1'b1;
        tick(); tick(); tick();
        din[2] = 1'b0;
        tick();
        n_checks++; if (dout !== '0 || rise !== '0 || evt_cnt !== e0) begin n_fail++; $display("FAIL glitch_reject got dout=%h rise=%h evt=%0d want 0 0 %0d", dout, rise, evt_cnt, e0); end
        din[2] = 1'b1;
        tick(); tick(); tick(); tick();
        n_checks++; if (dout[2] !== 1'b1 || rise[2] !== 1'b1) begin n_fail++; $display("FAIL glitch_accept got dout=%b rise=%b want 1 1", dout[2], rise[2]); end
        din[2] = 1'b0;
        tick(); tick(); tick(); tick();
        n_checks++; if (dout[2] !== 1'b0 || fall[2] !== 1'b1) begin n_fail++; $display("FAIL glitch_fall got dout=%b fall=%b want 0 1", dout[2], fall[2]); end
        n_checks++; if (evt_cnt !== m_evt) begin n_fail++; $display("FAIL glitch_evt got %0d want %0d", evt_cnt, m_evt); end
    endtask

    task automatic test_filt_zero();
        logic [EW-1:0] e0;
        settle();
        e0 = m_evt;
        din = 16'hA5A5;
        tick();
        n_checks++; if (dout !== 16'hA5A5) begin n_fail++; $display("FAIL f0_dout got %h want a5a5", dout); end
        n_checks++; if (rise !== 16'hA5A5) begin n_fail++; $display("FAIL f0_rise got %h want a5a5", rise); end
        n_checks++; if (evt_cnt !== e0 + 1'b1) begin n_fail++; $display("FAIL f0_evt got %0d want %0d", evt_cnt, e0 + 1'b1); end
        din = 16'h5A5A;
        tick();
        n_checks++; if (dout !== 16'h5A5A || rise !== 16'h5A5A || fall !== 16'hA5A5) begin n_fail++; $display("FAIL f0_swap got dout=%h rise=%h fall=%h", dout, rise, fall); end
    endtask

    task automatic test_filt_lower();
        settle();
        filt_len = 8'd10;
        din[1] = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_checks++; if (dout[1] !== 1'b0) begin n_fail++; $display("FAIL lower_hold got %b want 0", dout[1]); end
        filt_len = 8'd2;
        tick();
        n_checks++; if (dout[1] !== 1'b1 || rise[1] !== 1'b1) begin n_fail++; $display("FAIL lower_qual got dout=%b rise=%b want 1 1", dout[1], rise[1]); end
    endtask

    task automatic test_enable();
        settle();
        filt_len = 8'd4;
        din[3] = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (dout[3] !== 1'b0 || rise !== '0) begin n_fail++; $display("FAIL en_hold got dout=%b rise=%h", dout[3], rise); end
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        n_checks++; if (evt_cnt !== '0) begin n_fail++; $display("FAIL en_clr got %0d want 0", evt_cnt); end
        en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        n_checks++; if (dout[3] !== 1'b0) begin n_fail++; $display("FAIL en_restart got %b want 0", dout[3]); end
        tick();
        n_checks++; if (dout[3] !== 1'b1 || rise[3] !== 1'b1 || evt_cnt !== 16'd1) begin n_fail++; $display("FAIL en_qual got dout=%b rise=%b evt=%0d", dout[3], rise[3], evt_cnt); end
    endtask

    task automatic test_reset_mid();
        settle();
        filt_len = 8'd3;
        din[5] = 1'b1;
        tick(); tick();
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks++; if (dout !== INIT || evt_cnt !== '0) begin n_fail++; $display("FAIL rstmid got dout=%h evt=%0d", dout, evt_cnt); end
        @(negedge clk);
        rstn = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (dout[5] !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold got %b want 0", dout[5]); end
        tick();
        n_checks++; if (dout[5] !== 1'b1 || rise[5] !== 1'b1) begin n_fail++; $display("FAIL rstmid_qual got dout=%b rise=%b", dout[5], rise[5]); end
    endtask

    task automatic test_random();
        logic [DW-1:0] flips;
        int bad;
        settle();
        bad = 0;
        for (int k = 0; k < 3000; k++) begin
            flips = $urandom & $urandom;
            din = din ^ flips;
            en = ($urandom_range(0, 15) != 0);
            evt_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) filt_len = CW'($urandom_range(0, 3));
            tick();
            n_checks++;
            if ({dout, rise, fall, evt_cnt} !== {m_dout, m_rise, m_fall, m_evt}) begin
                n_fail++;
                if (bad < 10) $display("FAIL rand%0d got %h/%h/%h/%h want %h/%h/%h/%h", k, dout, rise, fall, evt_cnt, m_dout, m_rise, m_fall, m_evt);
                bad++;
            end
        end
    endtask

    task automatic test_wrap_and_clr();
        settle();
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        for (int k = 0; k < 65535; k++) begin
            din[0] = ~din[0];
            tick();
        end
        n_checks++; if (evt_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_full got %h want ffff", evt_cnt); end
        din[0] = ~din[0];
        tick();
        n_checks++; if (evt_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h want 0000", evt_cnt); end
        din[0] = ~din[0];
        tick();
        n_checks++; if (evt_cnt !== 16'h0001) begin n_fail++; $display("FAIL wrap_one got %h want 0001", evt_cnt); end
        din[0] = ~din[0];
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        n_checks++; if (evt_cnt !== 16'h0000 || (rise[0] | fall[0]) !== 1'b1) begin n_fail++; $display("FAIL clr_coinc got evt=%h rise=%b fall=%b", evt_cnt, rise[0], fall[0]); end
    endtask

    initial begin
        test_reset();
        test_basic_rise_fall();
        test_glitch();
        test_filt_zero();
        test_filt_lower();
        test_enable();
        test_reset_mid();
        test_random();
        test_wrap_and_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
